conv_win_ctrl: RTL

Sequencer for the K_H x K_W circular image window register in front of the PE array. It walks an IMG_H x IMG_W image in row stripes and issues column reads to the image buffer. It drives the window register's load_en/clear and presents each completed window to the PE with a valid/ready handshake. One start pulse processes the whole image; a done pulse ends it.

---
 rtl/conv_win_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/conv_win_ctrl.sv
// Column-read / window-load sequencer for a K_H x K_W circular window register.
// Optional stall counter output enabled by CONV_WIN_CTRL_STALL_CNT_EN.
module conv_win_ctrl #(
   parameter int unsigned IMG_H = 8,
   parameter int unsigned IMG_W = 8,
   parameter int unsigned K_H   = 3,
   parameter int unsigned K_W   = 3,
   parameter int unsigned ROW_W = $clog2(IMG_H),
   parameter int unsigned COL_W = $clog2(IMG_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             rd_en,
   output logic [ROW_W-1:0] rd_row,
   output logic [COL_W-1:0] rd_col,
   output logic             win_load_en,
   output logic             win_clear,
   output logic             win_valid,
   input  logic             win_ready,
   output logic [ROW_W-1:0] win_row,
   output logic [COL_W-1:0] win_col,
   output logic             busy,
   output logic             done
`ifdef CONV_WIN_CTRL_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   // Column counter needs one extra value to represent "all IMG_W columns loaded".
   localparam int unsigned CNT_W = $clog2(IMG_W + 1);
   localparam logic [CNT_W-1:0] KW_C     = CNT_W'(K_W);
   localparam logic [CNT_W-1:0] IMGW_C   = CNT_W'(IMG_W);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - K_H);
   localparam logic [COL_W-1:0] KW_COL   = COL_W'(K_W);

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StRd,
      StLd,
      StValid,
      StDone
   } state_e;

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [CNT_W-1:0]   col_q, col_d;
   logic [CNT_W-1:0]   col_inc;
   logic               abort_clr_q, abort_clr_d;

   assign col_inc = col_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      abort_clr_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StClr;
               row_d   = '0;
            end
         end
         StClr: begin
            col_d   = '0;
            state_d = StRd;
         end
         StRd: state_d = StLd;
         StLd: begin
            col_d   = col_inc;
            state_d = (col_inc >= KW_C) ? StValid : StRd;
         end
         StValid: begin
            if (win_ready) begin
               if (col_q < IMGW_C) begin
                  state_d = StRd;
               end else if (row_q < LAST_ROW) begin
                  row_d   = row_q + 1'b1;
                  state_d = StClr;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Abort wins over everything, including a same-cycle accept.
      if (abort && (state_q != StIdle)) begin
         state_d     = StIdle;
         abort_clr_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         row_q       <= '0;
         col_q       <= '0;
         abort_clr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         abort_clr_q <= abort_clr_d;
      end
   end

   always_comb begin
      busy        = (state_q != StIdle);
      rd_en       = (state_q == StRd);
      win_load_en = (state_q == StLd);
      win_valid   = (state_q == StValid);
      done        = (state_q == StDone);
      win_clear   = (state_q == StClr) || abort_clr_q;
      rd_row      = rd_en ? row_q : '0;
      rd_col      = rd_en ? col_q[COL_W-1:0] : '0;
      win_row     = win_valid ? row_q : '0;
      // col_q points one past the last loaded column.
      win_col     = win_valid ? (col_q[COL_W-1:0] - KW_COL) : '0;
   end

`ifdef CONV_WIN_CTRL_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if ((state_q == StIdle) && start) begin
         stall_q <= '0;
      end else if ((state_q == StValid) && !win_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule
